// File: rtl/adc_wave_meas.sv
// rtl/adc_wave_meas.sv - ADC sample clock, capture and per-window max/min/vpp/crossing measurement
//
// Purpose: divides sys_clk into the ADC sample clock, registers one sample per
// adc_clk period, and over each window of GATE_SAMPLES samples tracks max, min,
// peak-to-peak and hysteretic rising crossings, then publishes them with a
// one-cycle meas_valid strobe.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   adc_data   in   10-bit unsigned ADC code
//   adc_clk    out  ADC sample clock, sys_clk/CLK_DIV, 50% duty
//   v_max      out  maximum code in last window
//   v_min      out  minimum code in last window
//   vpp        out  v_max - v_min
//   freq_cnt   out  rising crossings in last window, saturating
//   meas_valid out  one-cycle pulse when the measurement outputs update

module adc_wave_meas #(
  parameter int CLK_DIV      = 2,
  parameter int GATE_SAMPLES = 25000,
  parameter int HYST         = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  adc_data,
  output logic        adc_clk,
  output logic [9:0]  v_max,
  output logic [9:0]  v_min,
  output logic [9:0]  vpp,
  output logic [15:0] freq_cnt,
  output logic        meas_valid
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IW   = (GATE_SAMPLES > 1) ? $clog2(GATE_SAMPLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(GATE_SAMPLES - 1);
  localparam logic [10:0]   HYST_W   = 11'(HYST);

  typedef enum logic [1:0] {ST_UNK, ST_LOW, ST_HIGH} cross_t;

  logic [DW-1:0] div_cnt;
  logic          sample_en;
  logic [9:0]    adc_q;
  logic          s_vld;

  logic [IW-1:0] samp_idx;
  logic [9:0]    run_max;
  logic [9:0]    run_min;
  logic [9:0]    thr;
  logic [15:0]   cross_cnt;
  cross_t        st;

  // Clock divider: sample_en marks the cycle right after adc_clk falls, half
  // an ADC period after the rising edge that launched new data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt   <= '0;
      adc_clk   <= 1'b0;
      sample_en <= 1'b0;
    end else begin
      sample_en <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        adc_clk   <= ~adc_clk;
        sample_en <= adc_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      adc_q <= '0;
      s_vld <= 1'b0;
    end else begin
      s_vld <= sample_en;
      if (sample_en) adc_q <= adc_data;
    end
  end

  // Hysteresis thresholds at 11 bits so neither side wraps before clamping.
  logic [10:0] thr_sum;
  logic [10:0] thr_hi;
  logic [10:0] thr_lo;
  logic        at_hi;
  logic        at_lo;
  cross_t      st_nxt;
  logic        cnt_inc;
  logic [15:0] cnt_nxt;
  logic        first_s;
  logic        last_s;
  logic [9:0]  max_nxt;
  logic [9:0]  min_nxt;
  logic [10:0] mid_sum;

  always_comb begin
    thr_sum = {1'b0, thr} + HYST_W;
    thr_hi  = (thr_sum > 11'd1023) ? 11'd1023 : thr_sum;
    thr_lo  = ({1'b0, thr} >= HYST_W) ? ({1'b0, thr} - HYST_W) : 11'd0;
    at_hi   = ({1'b0, adc_q} >= thr_hi);
    at_lo   = ({1'b0, adc_q} <= thr_lo);

    st_nxt  = st;
    cnt_inc = 1'b0;
    case (st)
      ST_UNK: begin
        if (at_hi)      st_nxt = ST_HIGH;
        else if (at_lo) st_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (at_hi) begin
          st_nxt  = ST_HIGH;
          cnt_inc = 1'b1;
        end
      end
      ST_HIGH: begin
        if (at_lo) st_nxt = ST_LOW;
      end
      default: st_nxt = ST_UNK;
    endcase
    cnt_nxt = (cnt_inc && (cross_cnt != 16'hFFFF)) ? cross_cnt + 16'd1 : cross_cnt;

    first_s = (samp_idx == '0);
    last_s  = (samp_idx == IDX_LAST);
    max_nxt = (first_s || (adc_q > run_max)) ? adc_q : run_max;
    min_nxt = (first_s || (adc_q < run_min)) ? adc_q : run_min;
    mid_sum = {1'b0, max_nxt} + {1'b0, min_nxt};
  end

  // Window bookkeeping; the crossing state deliberately survives window ends.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      samp_idx   <= '0;
      run_max    <= '0;
      run_min    <= '0;
      thr        <= 10'd512;
      cross_cnt  <= '0;
      st         <= ST_UNK;
      v_max      <= '0;
      v_min      <= '0;
      vpp        <= '0;
      freq_cnt   <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (s_vld) begin
        run_max <= max_nxt;
        run_min <= min_nxt;
        st      <= st_nxt;
        if (last_s) begin
          samp_idx   <= '0;
          v_max      <= max_nxt;
          v_min      <= min_nxt;
          vpp        <= max_nxt - min_nxt;
          freq_cnt   <= cnt_nxt;
          meas_valid <= 1'b1;
          cross_cnt  <= '0;
          thr        <= mid_sum[10:1];
        end else begin
          samp_idx  <= samp_idx + 1'b1;
          cross_cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule
